// File: rtl/vga_board_capture.sv
// rtl/vga_board_capture.sv - passive VGA monitor that rebuilds the displayed 8x8 Life board
//
// Purpose: watches the generator's hsync/vsync/RGB, samples each cell's centre
// pixel once per frame and publishes the 64-bit board at every vsync assertion.
//
// Ports:
//   clk          pixel clock (same clock as the generator)
//   reset        asynchronous, active-high
//   hsync, vsync active-low sync inputs
//   r, g, b      2-bit colour channels
//   board        last accepted board, bit row*8+col, 1 = alive
//   board_valid  one-cycle pulse when board updates
//   frame_error  one-cycle pulse when a frame is rejected
//   changed      last accepted board differed from the previous one
//   gen_count    number of accepted boards with changed=1 (wraps)
//   locked       set two cycles after the first vsync deassert after reset
module vga_board_capture #(
  parameter int H_BACK    = 48,
  parameter int V_BACK    = 33,
  parameter int CELL_SIZE = 24,
  parameter int H_ORIGIN  = 224,
  parameter int V_ORIGIN  = 144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [1:0]  r,
  input  logic [1:0]  g,
  input  logic [1:0]  b,
  output logic [63:0] board,
  output logic        board_valid,
  output logic        frame_error,
  output logic        changed,
  output logic [15:0] gen_count,
  output logic        locked
);

  // counter values that land on the centre pixel of row/col 0
  localparam int X0 = H_BACK + H_ORIGIN + CELL_SIZE / 2;
  localparam int Y0 = V_BACK + V_ORIGIN + CELL_SIZE / 2;

  localparam logic [5:0] RGB_ALIVE = 6'b00_00_00;
  localparam logic [5:0] RGB_DEAD  = 6'b10_10_10;

  logic       hs_q, vs_q, hs_qq, vs_qq;
  logic [5:0] rgb_q;
  logic       hs_rise, vs_rise, vs_fall;

  logic [9:0] x_cnt_q, y_cnt_q;
  logic [9:0] x_cnt, y_cnt;

  logic       col_hit, row_hit, sample;
  logic [2:0] col_idx, row_idx;
  logic [5:0] bit_idx;
  logic       pix_alive, pix_bad;

  logic [63:0] shadow;
  logic [6:0]  samp_cnt;
  logic        err_flag;
  logic        eof_q;
  logic        lock_pend;
  logic        board_diff;

  // Sync registers idle at 1 (deasserted) so leaving reset never looks like
  // a vsync deassert and cannot lock onto a partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hs_qq <= 1'b1;
      vs_qq <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= hsync;
      vs_q  <= vsync;
      hs_qq <= hs_q;
      vs_qq <= vs_q;
      rgb_q <= {r, g, b};
    end
  end

  assign hs_rise = hs_q & ~hs_qq;
  assign vs_rise = vs_q & ~vs_qq;
  assign vs_fall = ~vs_q & vs_qq;

  // x_cnt/y_cnt are the counts that describe the current rgb_q; the registers
  // only remember the previous cycle's value. x_cnt reads 0 in the very cycle
  // hs_q rises, which keeps the sample aligned with rgb_q (no skew).
  always_comb begin
    x_cnt = x_cnt_q;
    if (hs_rise)
      x_cnt = '0;
    else if (x_cnt_q != 10'h3FF)
      x_cnt = x_cnt_q + 10'd1;
  end

  always_comb begin
    y_cnt = y_cnt_q;
    if (vs_rise)
      y_cnt = '0;
    else if (hs_rise && (y_cnt_q != 10'h3FF))
      y_cnt = y_cnt_q + 10'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      x_cnt_q <= x_cnt;
      y_cnt_q <= y_cnt;
    end
  end

  // centre-pixel match against the eight column / row positions
  always_comb begin
    col_hit = 1'b0;
    col_idx = '0;
    row_hit = 1'b0;
    row_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (x_cnt == 10'(X0 + i * CELL_SIZE)) begin
        col_hit = 1'b1;
        col_idx = 3'(i);
      end
      if (y_cnt == 10'(Y0 + i * CELL_SIZE)) begin
        row_hit = 1'b1;
        row_idx = 3'(i);
      end
    end
  end

  assign sample    = locked & col_hit & row_hit;
  assign bit_idx   = {row_idx, col_idx};
  assign pix_alive = (rgb_q == RGB_ALIVE);
  assign pix_bad   = (rgb_q != RGB_ALIVE) && (rgb_q != RGB_DEAD);
  assign board_diff = (shadow != board);

  // Frame-end and lock events are staged one cycle so outputs move two edges
  // after the vsync edge is first seen on the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eof_q     <= 1'b0;
      lock_pend <= 1'b0;
      locked    <= 1'b0;
    end else begin
      eof_q     <= vs_fall & locked;
      lock_pend <= vs_rise;
      if (lock_pend)
        locked <= 1'b1;
    end
  end

  // shadow board and per-frame sample bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow   <= '0;
      samp_cnt <= '0;
      err_flag <= 1'b0;
    end else if (eof_q) begin
      samp_cnt <= '0;
      err_flag <= 1'b0;
    end else if (sample) begin
      shadow[bit_idx] <= pix_alive;
      if (samp_cnt == 7'd64)
        err_flag <= 1'b1;
      else
        samp_cnt <= samp_cnt + 7'd1;
      if (pix_bad)
        err_flag <= 1'b1;
    end
  end

  // accept / reject at end of frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board       <= '0;
      changed     <= 1'b0;
      gen_count   <= '0;
      board_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      board_valid <= 1'b0;
      frame_error <= 1'b0;
      if (eof_q) begin
        if ((samp_cnt == 7'd64) && !err_flag) begin
          board       <= shadow;
          changed     <= board_diff;
          gen_count   <= gen_count + {15'd0, board_diff};
          board_valid <= 1'b1;
        end else begin
          frame_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_board_capture.sv
// tb/tb_vga_board_capture.sv - scoreboard bench for vga_board_capture on a compact video timing
module tb_vga_board_capture;

  // compact timing: 40x36 active, board drawn with 4-pixel cells
  localparam int TB_H_BACK = 4;
  localparam int TB_V_BACK = 2;
  localparam int TB_CELL   = 4;
  localparam int TB_HO     = 2;
  localparam int TB_VO     = 2;

  localparam int HA = 40, HFP = 2, HSW = 4;
  localparam int H_TOTAL = HA + HFP + HSW + TB_H_BACK;   // 50
  localparam int VA = 36, VFP = 1, VSW = 2;
  localparam int V_TOTAL = VA + VFP + VSW + TB_V_BACK;   // 41
  localparam int EARLY_LINE = 26;                        // rows 0..5 only -> 48 samples
  localparam int RESET_LINE = 20;

  localparam int M_NORMAL = 0, M_BADPIX = 1, M_EARLY = 2, M_RESET = 3;
  localparam int K_NONE = 0, K_VALID = 1, K_ERROR = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync, vsync;
  logic [1:0]  r, g, b;
  logic [63:0] board;
  logic        board_valid, frame_error, changed, locked;
  logic [15:0] gen_count;

  vga_board_capture #(
    .H_BACK   (TB_H_BACK),
    .V_BACK   (TB_V_BACK),
    .CELL_SIZE(TB_CELL),
    .H_ORIGIN (TB_HO),
    .V_ORIGIN (TB_VO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .r          (r),
    .g          (g),
    .b          (b),
    .board      (board),
    .board_valid(board_valid),
    .frame_error(frame_error),
    .changed    (changed),
    .gen_count  (gen_count),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] brd;
    logic        chg;
    logic [15:0] gen;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          vs_low_cyc = 0;

  logic [63:0] m_board = '0;
  logic        m_changed = 1'b0;
  logic [15:0] m_gen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one pixel of the generator, driven at the falling edge
  task automatic drive_pixel(input int h, input int v, input logic [63:0] brd, input int mode);
    logic       hs, vs;
    logic [5:0] c;
    int         row, col;
    @(negedge clk);
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    c  = 6'b00_00_00;
    if (h < HA && v < VA) begin
      c = 6'b01_01_01;
      if (h >= TB_HO && h < TB_HO + 8 * TB_CELL && v >= TB_VO && v < TB_VO + 8 * TB_CELL) begin
        col = (h - TB_HO) / TB_CELL;
        row = (v - TB_VO) / TB_CELL;
        c = brd[row * 8 + col] ? 6'b00_00_00 : 6'b10_10_10;
        // corrupt the centre pixel of cell 10 (row 1, col 2)
        if (mode == M_BADPIX && row == 1 && col == 2 &&
            h == TB_HO + 2 * TB_CELL + TB_CELL / 2 && v == TB_VO + TB_CELL + TB_CELL / 2)
          c = 6'b01_10_10;
      end
    end
    hsync = hs;
    if (vsync && !vs)
      vs_low_cyc = cyc;
    vsync = vs;
    {r, g, b} = c;
    reset = (mode == M_RESET) && (v == RESET_LINE) && (h < 2);
  endtask

  task automatic run_frame(input logic [63:0] brd, input int mode, input int kind);
    exp_t e;
    int   v;
    if (kind == K_VALID) begin
      m_changed = (brd != m_board);
      m_gen     = m_gen + {15'd0, m_changed};
      m_board   = brd;
    end
    if (kind != K_NONE) begin
      e.kind = kind;
      e.brd  = m_board;
      e.chg  = m_changed;
      e.gen  = m_gen;
      sb_q.push_back(e);
    end
    v = 0;
    while (v < V_TOTAL) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        drive_pixel(h, v, brd, mode);
        if (mode == M_RESET && v == RESET_LINE && h == 4) begin
          m_board = '0; m_changed = 1'b0; m_gen = '0;
          check("rst_board", board, 64'h0);
          check("rst_gen_count", {48'h0, gen_count}, 64'h0);
          check("rst_changed", {63'h0, changed}, 64'h0);
          check("rst_locked", {63'h0, locked}, 64'h0);
        end
      end
      v++;
      if (mode == M_EARLY && v == EARLY_LINE)
        v = VA + VFP;
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (board_valid || frame_error) begin
        check("pulse_exclusive", {63'h0, board_valid & frame_error}, 64'h0);
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {62'h0, board_valid, frame_error}, 64'h0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", board_valid ? 64'd1 : 64'd2, 64'(e.kind));
          check("latency", 64'(cyc - vs_low_cyc), 64'd3);
          check("board", board, e.brd);
          check("changed", {63'h0, changed}, {63'h0, e.chg});
          check("gen_count", {48'h0, gen_count}, {48'h0, e.gen});
        end
        @(negedge clk);
        check("pulse_width", {62'h0, board_valid, frame_error}, 64'h0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    {r, g, b} = 6'b0;
    repeat (3) @(negedge clk);
    check("reset_board", board, 64'h0);
    check("reset_pulses", {62'h0, board_valid, frame_error}, 64'h0);
    check("reset_changed", {63'h0, changed}, 64'h0);
    check("reset_gen_count", {48'h0, gen_count}, 64'h0);
    check("reset_locked", {63'h0, locked}, 64'h0);

    // frame before lock: no pulse, lock at its vsync deassert
    run_frame(64'h0000_0000_0000_0008, M_NORMAL, K_NONE);
    check("locked_after_first", {63'h0, locked}, 64'h1);
    run_frame(64'h0000_0000_0000_0008, M_NORMAL, K_VALID);
    check("cell3_board", board, 64'h0000_0000_0000_0008);
    check("cell3_changed", {63'h0, changed}, 64'h1);
    check("cell3_gen", {48'h0, gen_count}, 64'd1);

    // identical frames
    run_frame(64'h8100_0000_0000_0081, M_NORMAL, K_VALID);
    run_frame(64'h8100_0000_0000_0081, M_NORMAL, K_VALID);
    check("same_changed", {63'h0, changed}, 64'h0);
    check("same_gen", {48'h0, gen_count}, 64'd2);

    // bad colour on cell 10, then a clean frame
    run_frame(64'h8100_0000_0000_0081, M_BADPIX, K_ERROR);
    check("err_board_hold", board, 64'h8100_0000_0000_0081);
    check("err_gen_hold", {48'h0, gen_count}, 64'd2);
    run_frame(64'h0123_4567_89AB_CDEF, M_NORMAL, K_VALID);

    // early vsync: 48 samples only
    run_frame(64'hFFFF_0000_FFFF_0000, M_EARLY, K_ERROR);
    run_frame(64'hFFFF_0000_FFFF_0000, M_NORMAL, K_VALID);
    check("early_gen", {48'h0, gen_count}, 64'd4);

    // reset mid-frame: partial frame ignored, relock
    run_frame(64'h0000_0000_0000_5555, M_RESET, K_NONE);
    check("relock", {63'h0, locked}, 64'h1);

    // blinker, five frames
    for (int i = 0; i < 5; i++)
      run_frame((i % 2 == 0) ? 64'h0000_0000_001C_0000 : 64'h0000_0000_0808_0800, M_NORMAL, K_VALID);
    check("blinker_board", board, 64'h0000_0000_001C_0000);
    check("blinker_gen", {48'h0, gen_count}, 64'd5);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
